// File: rtl/chip_pkg.sv
// Shared definitions for the controller-side byte packer: FSM states,
// the marker default and the header byte layout.
package chip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_HDR   = 3'd2,
        ST_B3    = 3'd3,
        ST_B2    = 3'd4,
        ST_B1    = 3'd5,
        ST_B0    = 3'd6,
        ST_ACK   = 3'd7
    } state_t;

    localparam logic [31:0] MARKER_DEFAULT = 32'h1010_1010;

    // Header layout: {px[1:0], mk, idx[2:0], sync[1:0]}
    localparam int          HDR_PX_LSB  = 6;
    localparam int          HDR_MK_BIT  = 5;
    localparam int          HDR_IDX_LSB = 2;
    localparam logic [1:0]  HDR_SYNC    = 2'b10;

    function automatic logic [7:0] make_header(input logic [1:0] px,
                                               input logic       mk,
                                               input logic [2:0] idx);
        logic [7:0] h;
        h                     = '0;
        h[HDR_PX_LSB +: 2]    = px;
        h[HDR_MK_BIT]         = mk;
        h[HDR_IDX_LSB +: 3]   = idx;
        h[1:0]                = HDR_SYNC;
        return h;
    endfunction

endpackage

// File: rtl/edge_fall_det.sv
// Falling-edge detector: registers the input and flags a 1->0 transition.
// RST_VAL sets the assumed previous level, so a low input out of reset with
// RST_VAL=0 is never reported as a fall.
module edge_fall_det #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= RST_VAL;
        else     d_q <= d;
    end

    assign fall = d_q & ~d;

endmodule

// File: rtl/sample_byte_packer.sv
// Latches a 32-bit sample on the drdy falling edge, prepends a tag header and
// streams the bytes MSB-first over valid/ready, then pulses ack_received.
module sample_byte_packer
    import chip_pkg::*;
#(
    parameter bit          HEADER_EN = 1'b1,
    parameter int          NUM_SAMP  = 5,
    parameter int          ACK_LEN   = 2,
    parameter logic [31:0] MARKER    = MARKER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sample_in,
    input  logic        drdy,
    input  logic [1:0]  px_addr,
    output logic        ack_received,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        overrun,
    output logic        busy
);

    localparam int AW = (ACK_LEN > 1) ? $clog2(ACK_LEN) : 1;

    // Handshake: a byte moves when tx_valid and tx_ready are both high at a
    // rising edge; tx_valid and tx_byte hold steady until that happens.

    state_t          state;
    logic [31:0]     samp_r;
    logic [1:0]      px_r;
    logic [2:0]      idx;
    logic [AW-1:0]   ack_cnt;
    logic            fall;
    logic            mk_now;
    logic [2:0]      idx_use;
    logic [2:0]      idx_next;
    logic [7:0]      hdr_byte;

    edge_fall_det #(.RST_VAL(1'b0)) u_drdy_fall (
        .clk  (clk),
        .rst  (rst),
        .d    (drdy),
        .fall (fall)
    );

    // Markers report idx 0 and leave the running index alone; a pixel change
    // restarts the index before it is used.
    always_comb begin
        mk_now   = (sample_in == MARKER);
        idx_use  = (mk_now || (px_addr != px_r)) ? 3'd0 : idx;
        idx_next = (idx_use == 3'(NUM_SAMP - 1)) ? 3'd0 : idx_use + 3'd1;
        hdr_byte = make_header(px_addr, mk_now, idx_use);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            samp_r       <= '0;
            px_r         <= '0;
            idx          <= '0;
            ack_cnt      <= '0;
            tx_byte      <= '0;
            tx_valid     <= 1'b0;
            ack_received <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (fall && state != ST_IDLE) overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state <= ST_LATCH;
                        busy  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    samp_r   <= sample_in;
                    px_r     <= px_addr;
                    if (!mk_now) idx <= idx_next;
                    tx_valid <= 1'b1;
                    if (HEADER_EN) begin
                        state   <= ST_HDR;
                        tx_byte <= hdr_byte;
                    end else begin
                        state   <= ST_B3;
                        tx_byte <= sample_in[31:24];
                    end
                end
                ST_HDR: if (tx_ready) begin
                    state   <= ST_B3;
                    tx_byte <= samp_r[31:24];
                end
                ST_B3: if (tx_ready) begin
                    state   <= ST_B2;
                    tx_byte <= samp_r[23:16];
                end
                ST_B2: if (tx_ready) begin
                    state   <= ST_B1;
                    tx_byte <= samp_r[15:8];
                end
                ST_B1: if (tx_ready) begin
                    state   <= ST_B0;
                    tx_byte <= samp_r[7:0];
                end
                ST_B0: if (tx_ready) begin
                    state        <= ST_ACK;
                    tx_byte      <= '0;
                    tx_valid     <= 1'b0;
                    ack_received <= 1'b1;
                    ack_cnt      <= '0;
                end
                ST_ACK: begin
                    if (ack_cnt == AW'(ACK_LEN - 1)) begin
                        state        <= ST_IDLE;
                        ack_received <= 1'b0;
                        busy         <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_byte_packer.sv
// Directed bench for sample_byte_packer: frame timing, index/marker headers,
// stalls, overrun and asynchronous reset.
module tb_sample_byte_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] sample_in;
    logic        drdy;
    logic [1:0]  px_addr;
    logic        ack_received;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        overrun;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sample_byte_packer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .drdy         (drdy),
        .px_addr      (px_addr),
        .ack_received (ack_received),
        .tx_byte      (tx_byte),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .overrun      (overrun),
        .busy         (busy)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input logic ovr);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_byte"},  32'(tx_byte), 32'd0);
        chk({tag, "_ack"},   32'(ack_received), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_ovr"},   32'(overrun), 32'(ovr));
    endtask

    // Full frame with tx_ready held high; drdy falls at the calling negedge.
    task automatic run_frame(input string tag, input logic [31:0] s,
                             input logic [1:0] px, input logic [7:0] hdr);
        logic [7:0] b[5];
        b[0] = hdr; b[1] = s[31:24]; b[2] = s[23:16]; b[3] = s[15:8]; b[4] = s[7:0];
        sample_in = s; px_addr = px; drdy = 1'b0;
        tick();
        chk({tag, "_latch_busy"},  32'(busy), 32'd1);
        chk({tag, "_latch_valid"}, 32'(tx_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("%s_valid%0d", tag, k), 32'(tx_valid), 32'd1);
            chk($sformatf("%s_byte%0d", tag, k),  32'(tx_byte), 32'(b[k]));
            chk($sformatf("%s_noack%0d", tag, k), 32'(ack_received), 32'd0);
        end
        tick();
        chk({tag, "_ack0"},    32'(ack_received), 32'd1);
        chk({tag, "_ackvld"},  32'(tx_valid), 32'd0);
        tick();
        chk({tag, "_ack1"},    32'(ack_received), 32'd1);
        chk({tag, "_ackbusy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_ackend"},  32'(ack_received), 32'd0);
        chk({tag, "_idle"},    32'(busy), 32'd0);
        drdy = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] sb[5];
        int k;
        int cyc;

        rst = 1'b1; drdy = 1'b1; tx_ready = 1'b1; sample_in = '0; px_addr = '0;
        tick(); tick();
        chk_quiet("reset", 1'b0);
        rst = 1'b0;
        tick(); tick();
        chk_quiet("post_reset", 1'b0);

        // Basic frame: header {2,0,0,10} = 0x82
        run_frame("deadbeef", 32'hDEADBEEF, 2'd2, 8'h82);

        // Index walks 0..4 on pixel 1 then wraps
        run_frame("px1_s0", 32'h0102_0304, 2'd1, 8'h42);
        run_frame("px1_s1", 32'h1122_3340, 2'd1, 8'h46);
        run_frame("px1_s2", 32'h5566_7788, 2'd1, 8'h4A);
        run_frame("px1_s3", 32'h99AA_BBCC, 2'd1, 8'h4E);
        run_frame("px1_s4", 32'hDDEE_FF00, 2'd1, 8'h52);
        run_frame("px1_s5", 32'h1357_9BDF, 2'd1, 8'h42);

        // Marker reports idx 0; next sample on same pixel keeps pre-marker idx 1
        run_frame("marker", 32'h1010_1010, 2'd0, 8'h22);
        run_frame("post_mk", 32'h2468_ACE0, 2'd0, 8'h06);

        // Stalled transfer, ready pattern 1,0,0 repeating; header idx 2
        sb[0] = 8'h0A; sb[1] = 8'hCA; sb[2] = 8'hFE; sb[3] = 8'hF0; sb[4] = 8'h0D;
        sample_in = 32'hCAFE_F00D; px_addr = 2'd0; drdy = 1'b0;
        tick();
        tick();
        k = 0; cyc = 0;
        while (k < 5 && cyc < 40) begin
            tx_ready = (cyc % 3 == 0);
            chk($sformatf("stall_valid_c%0d", cyc), 32'(tx_valid), 32'd1);
            chk($sformatf("stall_byte_c%0d", cyc),  32'(tx_byte), 32'(sb[k]));
            chk($sformatf("stall_noack_c%0d", cyc), 32'(ack_received), 32'd0);
            tick();
            if (tx_ready) k++;
            cyc++;
        end
        tx_ready = 1'b1;
        chk("stall_all_bytes", 32'(k), 32'd5);
        chk("stall_cycles", 32'(cyc), 32'd13);
        chk("stall_ack0", 32'(ack_received), 32'd1);
        tick();
        chk("stall_ack1", 32'(ack_received), 32'd1);
        tick();
        chk("stall_idle", 32'(busy), 32'd0);
        drdy = 1'b1;
        tick();

        // Overrun: second fall during B3 edge is seen while busy; header idx 3
        sample_in = 32'h1122_3344; px_addr = 2'd0; drdy = 1'b0;
        tick();
        tick();
        chk("ovr_hdr", 32'(tx_byte), 32'h0E);
        drdy = 1'b1;
        tick();
        chk("ovr_b3", 32'(tx_byte), 32'h11);
        chk("ovr_before", 32'(overrun), 32'd0);
        drdy = 1'b0; sample_in = 32'hFFFF_0000;
        tick();
        chk("ovr_b2", 32'(tx_byte), 32'h22);
        chk("ovr_set", 32'(overrun), 32'd1);
        tick();
        chk("ovr_b1", 32'(tx_byte), 32'h33);
        tick();
        chk("ovr_b0", 32'(tx_byte), 32'h44);
        tick();
        chk("ovr_ack0", 32'(ack_received), 32'd1);
        tick();
        chk("ovr_ack1", 32'(ack_received), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ovr_quiet%0d", i), 32'(tx_valid), 32'd0);
            chk($sformatf("ovr_busy%0d", i),  32'(busy), 32'd0);
            chk($sformatf("ovr_sticky%0d", i), 32'(overrun), 32'd1);
        end
        drdy = 1'b1;
        tick();

        // Reset in the middle of B1; header idx 4
        sample_in = 32'hA5A5_5A5A; px_addr = 2'd0; drdy = 1'b0;
        tick();
        tick();
        chk("rst_hdr", 32'(tx_byte), 32'h12);
        tick();
        chk("rst_b3", 32'(tx_byte), 32'hA5);
        tick();
        chk("rst_b2", 32'(tx_byte), 32'hA5);
        tick();
        chk("rst_b1", 32'(tx_byte), 32'h5A);
        #2 rst = 1'b1;
        #1 chk_quiet("async_rst", 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet($sformatf("held_low%0d", i), 1'b0);
        end
        drdy = 1'b1;
        tick();
        // idx and px_r both back to 0, so header is {0,0,0,10}
        run_frame("after_rst", 32'h0BAD_F00D, 2'd0, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_byte_packer.md
# sample_byte_packer

Byte-serialising stage directly downstream of the chip bus controller. Latches each 32-bit pixel sample when the controller signals data ready (active-low `drdy`) and prepends a tag header. Streams the header and sample bytes MSB-first to the I2C slave transmit interface over a valid/ready handshake. Returns the `ack_received` pulse that releases the controller from its transmit-wait state.

## Interface
- `HEADER_EN`, 1: 1 = send header byte before the 4 data bytes; 0 = data bytes only.
- `NUM_SAMP`, 5: samples per pixel before the sample index wraps; range 1..8.
- `ACK_LEN`, 2: cycles `ack_received` is held high; minimum 1.
- `MARKER`, 32'h10101010: sample value the controller emits as a cycle marker.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `sample_in` in 32: sample word from the controller; stable while `drdy`=0.
- `drdy` in 1: active-low data-ready from the controller.
- `px_addr` in 2: current pixel address from the controller.
- `ack_received` out 1: high for `ACK_LEN` cycles after the last byte is accepted.
- `tx_byte` out 8: byte offered to the I2C transmitter.
- `tx_valid` out 1: `tx_byte` is valid.
- `tx_ready` in 1: transmitter accepts the byte this cycle.
- `overrun` out 1: sticky; a `drdy` falling edge arrived while busy.
- `busy` out 1: high from latch until ack completes.

## Operation
- `drdy_q` is `drdy` registered, reset 0. Fall event = `drdy_q`=1 & `drdy`=0. A `drdy` held low out of reset is never a fall.
- States:
  - IDLE → LATCH on fall.
  - LATCH (1 cycle) → HDR if `HEADER_EN`, else B3.
  - HDR → B3 → B2 → B1 → B0. Each state holds until `tx_valid`&`tx_ready`.
  - B0 → ACK on transfer.
  - ACK counts `ACK_LEN` cycles → IDLE.
- LATCH captures:
  - `sample_in` into `samp_r`.
  - `px_addr` into `px_r`.
  - `mk` = (`sample_in`==`MARKER`).
- Header byte = {`px_r`[1:0], `mk`, `idx`[2:0], 2'b10}.
- Data bytes in order: B3 = `samp_r`[31:24], B2 = [23:16], B1 = [15:8], B0 = [7:0].
- Sample index `idx` (3 bits):
  - Non-marker sample, latched `px_addr` equals the previous `px_r`: header uses current `idx`, then `idx` increments, wrapping `NUM_SAMP`-1 → 0.
  - Non-marker sample, latched `px_addr` differs from the previous `px_r`: `idx` resets to 0 before use.
  - Marker sample: header carries `idx`=0 and `mk`=1. `idx` is left unchanged.
- Fall while not IDLE: sample dropped, `overrun` set. `overrun` clears only on `rst`.
- `tx_byte` is don't-care when `tx_valid`=0; drive 0.
- Reset mid-operation:
  - Return to IDLE immediately.
  - `tx_valid`, `ack_received`, `busy` and `overrun` = 0.
  - `idx` = 0, `px_r` = 0.
  - Any partial frame is abandoned.

## Timing
- Reset values: all outputs 0; `drdy_q` 0.
- Fall seen at edge N → LATCH at N+1. `tx_valid`=1 with the first byte from N+2.
- Each byte holds `tx_valid` and `tx_byte` stable until accepted. One byte per cycle when `tx_ready` is tied high.
- Full frame with `tx_ready`=1 and `HEADER_EN`=1:
  - Fall at cycle 0.
  - Bytes at cycles 2–6.
  - `ack_received` high on cycles 7..(6+`ACK_LEN`).
- The controller edge-detects ack, so a single high cycle suffices. `ACK_LEN` > 1 adds margin.
- `busy` = 1 in every state except IDLE.
- Fall in the same cycle ACK ends: counts as overrun (state not yet IDLE).

## Structure
- Shared package `chip_pkg` holds:
  - State enum.
  - `MARKER` default.
  - Header field positions and sync pattern 2'b10.
- One sub-module: `edge_fall_det` (registered falling-edge detector, async reset, parametrised reset level). The same detector is reusable for `ack_received` on the controller side.

## Test plan
- `sample_in`=32'hDEADBEEF, `px_addr`=2, `drdy` falls, `tx_ready`=1 → bytes 0x82, 0xDE, 0xAD, 0xBE, 0xEF on cycles 2–6. `ack_received` high on cycles 7–8.
- Five samples on `px_addr`=1, then a sixth → header idx 0,1,2,3,4 then 0 (wrap). Headers 0x42, 0x46, 0x4A, 0x4E, 0x52, 0x42.
- Sample 32'h10101010 on `px_addr`=0 → header 0x22. The next non-marker sample on `px_addr`=0 keeps the pre-marker `idx`.
- `tx_ready` toggling 1-0-0-1… → each byte held stable while stalled. No byte is lost or duplicated. Ack occurs only after B0 is accepted.
- Second `drdy` fall during B2 → `overrun`=1 (sticky). The current frame completes unchanged and the second sample is never transmitted.
- `rst` asserted mid-B1 → all outputs 0 asynchronously. After release, `drdy` held low produces no frame until it rises and falls again.
